// File: rtl/perm_pkg.sv
// Shared definitions for the programmable bit-permutation engine: the
// configuration FSM state type and the classic DES permutation tables,
// already converted to 0-based indices with bit 0 as the LSB.
package perm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      APPLY = 2'd2
   } perm_state_t;

   // DES P-box: output bit i takes input bit DES_P_MAP[i]
   localparam logic [4:0] DES_P_MAP [32] = '{
       7, 28, 21, 10, 26,  2, 19, 13,
      23, 29,  5,  0, 18,  8, 24, 30,
      22,  1, 14, 27,  6,  9, 17, 31,
      15,  4, 20,  3, 11, 12, 25, 16
   };

   // DES initial permutation
   localparam logic [5:0] DES_IP_MAP [64] = '{
      57, 49, 41, 33, 25, 17,  9,  1,
      59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,
      63, 55, 47, 39, 31, 23, 15,  7,
      56, 48, 40, 32, 24, 16,  8,  0,
      58, 50, 42, 34, 26, 18, 10,  2,
      60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6
   };

   // DES final permutation (inverse of the initial permutation)
   localparam logic [5:0] DES_FP_MAP [64] = '{
      39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,
      37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,
      35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,
      33,  1, 41,  9, 49, 17, 57, 25,
      32,  0, 40,  8, 48, 16, 56, 24
   };

endpackage

// File: rtl/perm_unit_xbar.sv
// Combinational crossbar: every output bit is a WIDTH-way mux selecting one
// input bit according to its entry in the map.
module perm_xbar
   import perm_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [IDX_W-1:0] map [WIDTH],
   output logic [WIDTH-1:0] result
);

   // Route input bit map[i] to output bit i
   always_comb begin
      result = '0;
      for (int i = 0; i < WIDTH; i++) begin
         result[i] = data[map[i]];
      end
   end

endmodule

// File: rtl/perm_unit.sv
// Programmable bit-permutation engine with valid/ready streaming. A shadow map
// is written entry by entry, checked for bijectivity one entry per cycle while
// building its inverse, and only swapped into the active tables if the check
// succeeds. The datapath keeps running on the old tables throughout.
module perm_unit #(
   parameter int WIDTH = 32,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [IDX_W-1:0] cfg_src,
   input  logic             cfg_commit,
   output logic             cfg_busy,
   output logic             cfg_done,
   output logic             cfg_error,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_inverse,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   import perm_pkg::*;

   logic [IDX_W-1:0] shadow     [WIDTH];
   logic [IDX_W-1:0] inv_shadow [WIDTH];
   logic [IDX_W-1:0] active     [WIDTH];
   logic [IDX_W-1:0] inverse    [WIDTH];
   logic [IDX_W-1:0] sel_map    [WIDTH];

   perm_state_t      state;
   logic [IDX_W-1:0] k;
   logic [WIDTH-1:0] seen;
   logic             err;
   logic [IDX_W-1:0] chk_src;
   logic             chk_bad;
   logic [WIDTH-1:0] xbar_out;
   logic             accept;

   assign cfg_busy = (state != IDLE);
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign chk_src  = shadow[k];
   assign chk_bad  = (int'(chk_src) >= WIDTH) || seen[chk_src];

   // Shadow map writes, accepted only while idle and only for real bit positions
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < WIDTH; i++) shadow[i] <= IDX_W'(i);
      end else if (cfg_we && (state == IDLE) && (int'(cfg_idx) < WIDTH)) begin
         shadow[cfg_idx] <= cfg_src;
      end
   end

   // Commit FSM: walk the shadow map, flag out-of-range or repeated sources, build the inverse
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         k         <= '0;
         seen      <= '0;
         err       <= 1'b0;
         cfg_done  <= 1'b0;
         cfg_error <= 1'b0;
         for (int i = 0; i < WIDTH; i++) inv_shadow[i] <= IDX_W'(i);
      end else begin
         cfg_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_commit) begin
                  state <= CHECK;
                  k     <= '0;
                  seen  <= '0;
                  err   <= 1'b0;
               end
            end
            CHECK: begin
               if (chk_bad) begin
                  err <= 1'b1;
               end else begin
                  seen[chk_src]       <= 1'b1;
                  inv_shadow[chk_src] <= k;
               end
               if (k == IDX_W'(WIDTH - 1)) state <= APPLY;
               else                        k     <= k + 1'b1;
            end
            APPLY: begin
               cfg_error <= err;
               cfg_done  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Swap in the checked map and its inverse only when the check found no fault
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            active[i]  <= IDX_W'(i);
            inverse[i] <= IDX_W'(i);
         end
      end else if ((state == APPLY) && !err) begin
         active  <= shadow;
         inverse <= inv_shadow;
      end
   end

   // Pick forward or inverse table for the transaction being offered
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         sel_map[i] = in_inverse ? inverse[i] : active[i];
      end
   end

   perm_xbar #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_xbar (
      .data   (in_data),
      .map    (sel_map),
      .result (xbar_out)
   );

   // Single output register, held while downstream stalls
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= xbar_out;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_perm_unit.sv
// Self-checking bench for perm_unit: directed vectors push their expected
// result into a scoreboard queue, and an independent monitor pops and compares
// every word the DUT hands over.
module tb_perm_unit;

   import perm_pkg::*;

   localparam int WIDTH = 32;
   localparam int IDX_W = 5;

   logic             clk = 1'b0;
   logic             n_rst = 1'b1;
   logic             cfg_we = 1'b0;
   logic [IDX_W-1:0] cfg_idx = '0;
   logic [IDX_W-1:0] cfg_src = '0;
   logic             cfg_commit = 1'b0;
   logic             cfg_busy;
   logic             cfg_done;
   logic             cfg_error;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_inverse = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_data;

   logic [WIDTH-1:0] sb [$];
   int vectors = 0;
   int miscompares = 0;

   perm_unit #(
      .WIDTH (WIDTH)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_src    (cfg_src),
      .cfg_commit (cfg_commit),
      .cfg_busy   (cfg_busy),
      .cfg_done   (cfg_done),
      .cfg_error  (cfg_error),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_inverse (in_inverse),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Offer one transaction; leaves in_valid high so calls can run back to back
   task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic inv, input logic [WIDTH-1:0] expected);
      bit accepted = 0;
      in_valid   = 1'b1;
      in_data    = data;
      in_inverse = inv;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(expected);
            accepted = 1;
            break;
         end
      end
      checkOutput("accept", 64'(accepted), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idleInput();
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int t = 0; t < 50; t++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0) break;
      end
      checkOutput("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic writeEntry(input int idx, input int src);
      cfg_we  = 1'b1;
      cfg_idx = 5'(idx);
      cfg_src = 5'(src);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   // Commit, optionally poke a write and commit mid-check, and time the busy window
   task automatic commitAndWait(input logic exp_err, input bit inject);
      int  cycles = 0;
      bit  done_seen = 0;
      cfg_commit = 1'b1;
      @(posedge clk);
      #1;
      cfg_commit = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (cfg_done) begin
            done_seen = 1;
            break;
         end
         if (cfg_busy) cycles++;
         if (inject && cycles == 5) begin
            cfg_we = 1'b1;
            cfg_idx = 5'd0;
            cfg_src = 5'd31;
            cfg_commit = 1'b1;
         end else if (inject && cycles == 6) begin
            cfg_we = 1'b0;
            cfg_commit = 1'b0;
         end
      end
      checkOutput("done_seen", 64'(done_seen), 64'd1);
      checkOutput("busy_cycles", 64'(cycles), 64'(WIDTH + 1));
      checkOutput("busy_at_done", 64'(cfg_busy), 64'd0);
      checkOutput("cfg_error", 64'(cfg_error), 64'(exp_err));
      @(negedge clk);
      checkOutput("done_pulse", 64'(cfg_done), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: compare every handed-over word against the queue head
   always @(negedge clk) begin
      if (n_rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_output: got %h, expected none", out_data);
         end else begin
            checkOutput("out_data", 64'(out_data), 64'(sb.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      miscompares++;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      // Reset state
      #2 n_rst = 1'b0;
      #10;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_data", 64'(out_data), 64'd0);
      checkOutput("rst_cfg_busy", 64'(cfg_busy), 64'd0);
      checkOutput("rst_cfg_done", 64'(cfg_done), 64'd0);
      checkOutput("rst_cfg_error", 64'(cfg_error), 64'd0);
      @(posedge clk);
      #1 n_rst = 1'b1;

      // Identity after reset
      applyStimulus(32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
      idleInput();
      waitDrain();

      // Rotate map
      for (int i = 0; i < WIDTH; i++) writeEntry(i, (i + 1) % WIDTH);
      commitAndWait(1'b0, 1'b0);
      applyStimulus(32'h00000001, 1'b0, 32'h80000000);
      applyStimulus(32'h00000001, 1'b1, 32'h00000002);
      idleInput();
      waitDrain();

      // Backpressure under the rotate map
      out_ready = 1'b0;
      applyStimulus(32'h00000001, 1'b0, 32'h80000000);
      in_data = 32'h00000002;
      in_inverse = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
         checkOutput("stall_out_data", 64'(out_data), 64'h80000000);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      applyStimulus(32'h00000002, 1'b0, 32'h00000001);
      applyStimulus(32'h00000003, 1'b0, 32'h80000001);
      idleInput();
      waitDrain();

      // Duplicate source is rejected and the old map survives
      writeEntry(21, 5);
      commitAndWait(1'b1, 1'b0);
      applyStimulus(32'h00000001, 1'b0, 32'h80000000);
      idleInput();
      waitDrain();
      writeEntry(21, 22);
      commitAndWait(1'b0, 1'b0);
      applyStimulus(32'h00000002, 1'b0, 32'h00000001);
      idleInput();
      waitDrain();

      // Writes and commits during a check are ignored
      for (int i = 0; i < WIDTH; i++) writeEntry(i, i ^ 1);
      commitAndWait(1'b0, 1'b1);
      applyStimulus(32'h00000001, 1'b0, 32'h00000002);
      applyStimulus(32'h00000005, 1'b0, 32'h0000000A);
      applyStimulus(32'h00000005, 1'b1, 32'h0000000A);
      idleInput();
      waitDrain();

      // DES P-box table
      for (int i = 0; i < WIDTH; i++) writeEntry(i, int'(DES_P_MAP[i]));
      commitAndWait(1'b0, 1'b0);
      applyStimulus(32'h00000001, 1'b0, 32'h00000800);
      applyStimulus(32'h00000001, 1'b1, 32'h00000080);
      applyStimulus(32'h00000800, 1'b1, 32'h00000001);
      idleInput();
      waitDrain();

      // Reset in the middle of a check
      cfg_commit = 1'b1;
      @(posedge clk);
      #1 cfg_commit = 1'b0;
      out_ready = 1'b0;
      applyStimulus(32'h00000001, 1'b0, 32'h00000800);
      idleInput();
      repeat (9) @(posedge clk);
      #2;
      checkOutput("pre_rst_busy", 64'(cfg_busy), 64'd1);
      checkOutput("pre_rst_out_valid", 64'(out_valid), 64'd1);
      n_rst = 1'b0;
      #1;
      checkOutput("mid_rst_busy", 64'(cfg_busy), 64'd0);
      checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
      sb.delete();
      @(posedge clk);
      #1 n_rst = 1'b1;
      out_ready = 1'b1;
      applyStimulus(32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
      applyStimulus(32'h00000001, 1'b1, 32'h00000001);
      idleInput();
      waitDrain();
      commitAndWait(1'b0, 1'b0);
      applyStimulus(32'h80000001, 1'b0, 32'h80000001);
      idleInput();
      waitDrain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
